ram_line_master: RTL
====================

Name: ram_line_master

Overview:
- Initiator side of the cpu_ram_if RAM protocol.
- Accepts one cache-line transfer request (read fill or write-back) from a cache controller.
- Breaks each request into sequential single-word accesses on ramREN/ramWEN/ramaddr/ramstore.
- Waits on ramstate for each word, then returns the assembled line with one completion pulse, plus error/timeout detection.

Parameters:
WORDS, 4, words per line (power of 2, 2..16); line is WORDS*32 bits, byte-aligned to WORDS*4.
TIMEOUT, 64, max cycles spent on one word before abort; must exceed ram latency + 2; counter is 8 bits.

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block idle, request accepted when req_valid&&req_ready
req_write  in  1  1 = write line, 0 = read line
req_addr  in  32  line address; low log2(WORDS*4) bits ignored (forced 0)
req_wdata  in  WORDS*32  write line; word i at bits [32i+31:32i]
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  valid with resp_valid: transfer aborted
resp_rdata  out  WORDS*32  read line, same packing; held until next accept
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM word address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid when ramstate==ACCESS
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from mem_types_pkg

Behaviour:
- Reset (nRST low at an edge):
  - State IDLE; req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0.
  - ramREN=ramWEN=0; ramaddr=0; ramstore=0; word index and wait counter 0.
  - Reset mid-transfer aborts silently, with no resp_valid.
  - ramstate is ignored while nRST is low.
- States IDLE, XFER, RESP. ram outputs are registered, decoded from state/index.
- IDLE:
  - req_ready=1, ram enables 0.
  - On accept: latch base = req_addr with low bits zeroed, latch write flag and req_wdata.
  - Clear idx and wait counter, clear resp_rdata, go to XFER.
- XFER:
  - req_ready=0.
  - ramaddr = base + 4*idx.
  - ramREN = !write, ramWEN = write; never both.
  - ramstore = wdata word idx when writing, else 0.
  - Address, enables and data stay stable until ACCESS is seen.
  - Wait counter increments each XFER cycle without ACCESS.
- Per XFER cycle, in priority order:
  - ramstate==ERROR: abort to RESP with error=1.
  - ramstate==ACCESS:
    - On a read, capture ramload into resp_rdata word idx.
    - If idx==WORDS-1, go to RESP with error=0.
    - Otherwise idx++ and clear the wait counter. The next word's address appears the next cycle with no idle gap.
  - Wait counter == TIMEOUT-1 without ACCESS: abort to RESP with error=1.
- Abort leaves partially captured read words in resp_rdata; contents are undefined to the consumer when resp_error=1.
- RESP:
  - Exactly one cycle: resp_valid=1 and resp_error per the above; ram enables 0.
  - Next state IDLE. resp_error returns to 0 the cycle after.
- Latency:
  - Against a RAM of latency L, each word takes L+2 XFER cycles.
  - resp_valid asserts WORDS*(L+2) cycles after the accept edge (first XFER cycle counted as 1).
- Back-to-back: a new request is accepted no earlier than the IDLE cycle after RESP, so there is a minimum 1-cycle gap between resp_valid and the next ram drive.
- ramaddr arithmetic is 32-bit; a line never crosses its aligned boundary, so no wrap occurs within a line.
- Inputs req_* are ignored outside IDLE.

Test Plan:
1. RAM LAT=10, words 0x11,0x22,0x33,0x44 at 0x100..0x10C; read, req_addr=0x104.
   - ramaddr sequence 0x100,0x104,0x108,0x10C.
   - resp_rdata={0x44,0x33,0x22,0x11}, resp_error=0.
   - resp_valid 48 cycles after accept, for exactly 1 cycle.
2. Write line 0x200 data {0xA3,0xA2,0xA1,0xA0}, then read 0x200.
   - ramWEN high only in XFER, ramREN low throughout the write.
   - Readback equals written line.
3. Force ramstate=ERROR during word 2 of a read.
   - Next cycle resp_valid=1, resp_error=1, ramREN=0.
   - Following cycle req_ready=1.
4. Hold ramstate=BUSY, TIMEOUT=64.
   - resp_valid with resp_error=1 on the 65th cycle after accept.
   - ramaddr stuck at base during the wait.
5. Assert nRST low for one edge while on word 1 of a write.
   - Next cycle all ram outputs 0, req_ready=1, no resp_valid.
   - A subsequent read completes normally.
6. req_valid held high with two queued requests.
   - Second accept occurs in the IDLE cycle after the first resp_valid.
   - No ram enable is asserted during RESP.

Source files
------------

// File: rtl/mem_types_pkg.sv
// Shared RAM protocol types for the cpu_ram_if handshake.
// ramstate_t is the RAM's per-cycle status toward the initiator.
package mem_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_line_master.sv
// Cache-line initiator for the cpu_ram_if RAM protocol.
// Splits one line read/write into sequential single-word RAM accesses.
module ram_line_master
  import mem_types_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [WORDS*32-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_error,
  output logic [WORDS*32-1:0] resp_rdata,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  ramstate_t           ramstate
);

  localparam int LW  = WORDS * 32;
  localparam int IW  = $clog2(WORDS);
  localparam int OFS = IW + 2;

  localparam logic [31:0]   ADDR_MASK = 32'(WORDS * 4 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WORDS - 1);
  localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    wait_q, wait_d;
  logic [31:0]   base_q, base_d;
  logic          write_q, write_d;
  logic [LW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          rerror_q, rerror_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    base_d   = base_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rerror_d = 1'b0;

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_valid) begin
          base_d  = req_addr & ~ADDR_MASK;
          write_d = req_write;
          wdata_d = req_wdata;
          idx_d   = '0;
          wait_d  = '0;
          rdata_d = '0;
          state_d = S_XFER;
        end
      end
      (state_q == S_XFER): begin
        if (ramstate == ERROR) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerror_d = 1'b1;
        end else if (ramstate == ACCESS) begin
          for (int i = 0; i < WORDS; i++) begin
            if (!write_q && idx_q == IW'(i)) begin
              rdata_d[i*32 +: 32] = ramload;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            wait_d = '0;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rerror_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM drive is decoded from next state so it is registered yet
  // lands on the first XFER cycle and moves on the cycle after ACCESS.
  always_comb begin
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = '0;
    store_d = '0;
    if (state_d == S_XFER) begin
      ren_d  = !write_d;
      wen_d  = write_d;
      addr_d = base_d + {{(32-OFS){1'b0}}, idx_d, 2'b00};
      for (int i = 0; i < WORDS; i++) begin
        if (write_d && idx_d == IW'(i)) begin
          store_d = wdata_d[i*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      base_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerror_q <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      base_q   <= base_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerror_q <= rerror_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = rvalid_q;
  assign resp_error = rerror_q;
  assign resp_rdata = rdata_q;
  assign ramREN     = ren_q;
  assign ramWEN     = wen_q;
  assign ramaddr    = addr_q;
  assign ramstore   = store_q;

endmodule
